// File: rtl/switch_traversal_stage_if.sv
// Switch traversal stage bus bundle.
// Carries the allocator-side inputs (flits, valid, productive vectors, grant rows,
// stats clear) and the registered output-port side (flits, valid, deflect flags,
// integrity errors, deflection counter).
//   master : the allocator / upstream side, drives the *_in, vector and stats_clr signals
//   slave  : switch_traversal_stage, drives the output-port and status signals
interface switch_traversal_stage_if #(
  parameter int unsigned NUM_PORT = 6,
  parameter int unsigned WIDTH_PV = 6,
  parameter int unsigned FLIT_W   = 64
);
  logic [NUM_PORT*FLIT_W-1:0]   flit_in;
  logic [NUM_PORT-1:0]          valid_in;
  logic [NUM_PORT*WIDTH_PV-1:0] prod_vector;
  logic [NUM_PORT*NUM_PORT-1:0] alloc_vector;
  logic                         stats_clr;
  logic [NUM_PORT*FLIT_W-1:0]   flit_out;
  logic [NUM_PORT-1:0]          valid_out;
  logic [NUM_PORT-1:0]          deflect_out;
  logic                         err_conflict;
  logic                         err_sticky;
  logic [15:0]                  defl_count;

  modport master (
    output flit_in, valid_in, prod_vector, alloc_vector, stats_clr,
    input  flit_out, valid_out, deflect_out, err_conflict, err_sticky, defl_count
  );

  modport slave (
    input  flit_in, valid_in, prod_vector, alloc_vector, stats_clr,
    output flit_out, valid_out, deflect_out, err_conflict, err_sticky, defl_count
  );
endinterface

// File: rtl/switch_traversal_stage.sv
// switch_traversal_stage
// Output side of the port allocator. Each cycle, every valid flit is steered by the
// lowest set bit of its one-hot grant row into a registered output-port slot (latency 1).
// On a port collision the lowest-index flit wins and the others are dropped. Flits sent
// to a port outside their productive vector are flagged as deflected. Allocator
// integrity errors (collision, all-zero row, multi-hot row) pulse err_conflict and
// latch err_sticky until reset.
// Optional build macro: DEFLECT_STATS_EN enables the saturating 16-bit deflection
// counter (defl_count, cleared by stats_clr). Without it defl_count is tied to 0.
// Ports:
//   clk, reset (synchronous, active-high)
//   bus (slave)  : flit_in, valid_in, prod_vector, alloc_vector, stats_clr  -> in
//                  flit_out, valid_out, deflect_out, err_conflict, err_sticky,
//                  defl_count                                              -> out
module switch_traversal_stage #(
  parameter int unsigned NUM_PORT = 6,
  parameter int unsigned WIDTH_PV = 6,
  parameter int unsigned FLIT_W   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  switch_traversal_stage_if.slave bus
);

  localparam logic [NUM_PORT-1:0] ONE = {{(NUM_PORT-1){1'b0}}, 1'b1};

  logic [NUM_PORT*FLIT_W-1:0] nxt_flit;
  logic [NUM_PORT-1:0]        nxt_valid;
  logic [NUM_PORT-1:0]        nxt_defl;
  logic                       nxt_err;

  logic [NUM_PORT*FLIT_W-1:0] flit_q;
  logic [NUM_PORT-1:0]        valid_q;
  logic [NUM_PORT-1:0]        defl_q;
  logic                       errp_q;
  logic                       errs_q;
  logic [15:0]                cnt_q;

  // Crossbar steering. Rows are scanned in ascending flit index, so the first flit
  // to claim a port is the lowest-index winner; later claimants are dropped and flagged.
  always_comb begin
    nxt_flit  = '0;
    nxt_valid = '0;
    nxt_defl  = '0;
    nxt_err   = 1'b0;
    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      logic [NUM_PORT-1:0] row;
      logic [NUM_PORT-1:0] grant;
      logic [NUM_PORT-1:0] prow;
      row   = bus.alloc_vector[i*NUM_PORT +: NUM_PORT];
      grant = row & (~row + ONE);
      prow  = NUM_PORT'(bus.prod_vector[i*WIDTH_PV +: WIDTH_PV]);
      if (bus.valid_in[i]) begin
        if (row == '0 || (row & (row - ONE)) != '0) begin
          nxt_err = 1'b1;
        end
        for (int unsigned j = 0; j < NUM_PORT; j++) begin
          if (grant[j]) begin
            if (nxt_valid[j]) begin
              nxt_err = 1'b1;
            end else begin
              nxt_valid[j]                   = 1'b1;
              nxt_flit[j*FLIT_W +: FLIT_W]   = bus.flit_in[i*FLIT_W +: FLIT_W];
              nxt_defl[j]                    = ~prow[j];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_q  <= '0;
      valid_q <= '0;
      defl_q  <= '0;
      errp_q  <= 1'b0;
      errs_q  <= 1'b0;
    end else begin
      flit_q  <= nxt_flit;
      valid_q <= nxt_valid;
      defl_q  <= nxt_defl;
      errp_q  <= nxt_err;
      errs_q  <= errs_q | nxt_err;
    end
  end

`ifdef DEFLECT_STATS_EN
  logic [16:0] defl_sum;

  // One spare bit catches overflow so the counter can saturate instead of wrapping.
  always_comb begin
    defl_sum = {1'b0, cnt_q};
    for (int unsigned j = 0; j < NUM_PORT; j++) begin
      defl_sum = defl_sum + 17'(nxt_defl[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bus.stats_clr) begin
      cnt_q <= '0;
    end else if (defl_sum[16]) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= defl_sum[15:0];
    end
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = bus.stats_clr;
  assign cnt_q = '0;
`endif

  assign bus.flit_out     = flit_q;
  assign bus.valid_out    = valid_q;
  assign bus.deflect_out  = defl_q;
  assign bus.err_conflict = errp_q;
  assign bus.err_sticky   = errs_q;
  assign bus.defl_count   = cnt_q;

endmodule

// File: tb/tb_switch_traversal_stage.sv
module tb_switch_traversal_stage;
  localparam int NP = 6;
  localparam int PV = 6;
  localparam int FW = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  switch_traversal_stage_if #(.NUM_PORT(NP), .WIDTH_PV(PV), .FLIT_W(FW)) bus ();

  switch_traversal_stage #(.NUM_PORT(NP), .WIDTH_PV(PV), .FLIT_W(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NP*FW-1:0] flit;
    logic [NP-1:0]    v;
    logic [NP-1:0]    d;
    logic             ec;
    logic             es;
    logic [15:0]      cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_sticky = 1'b0;
  int   m_cnt    = 0;

  function automatic int lowest(logic [NP-1:0] r);
    for (int b = 0; b < NP; b++) if (r[b]) return b;
    return -1;
  endfunction

  // Reference model: works per output port from the rules, pushes one expectation per cycle.
  task automatic push_expected();
    exp_t e;
    int   claims[NP];
    logic err;
    logic [NP-1:0] row;
    int   p;
    e.flit = '0; e.v = '0; e.d = '0; e.ec = 1'b0; e.es = 1'b0;
    for (int k = 0; k < NP; k++) claims[k] = 0;
    if (reset) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end else begin
      err = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (bus.valid_in[i]) begin
          row = bus.alloc_vector[i*NP +: NP];
          if (row == '0 || $countones(row) > 1) err = 1'b1;
          p = lowest(row);
          if (p >= 0) begin
            claims[p]++;
            if (claims[p] == 1) begin
              e.flit[p*FW +: FW] = bus.flit_in[i*FW +: FW];
              e.v[p] = 1'b1;
              e.d[p] = !bus.prod_vector[i*PV + p];
            end
          end
        end
      end
      for (int k = 0; k < NP; k++) if (claims[k] > 1) err = 1'b1;
      e.ec = err;
      m_sticky = m_sticky | err;
`ifdef DEFLECT_STATS_EN
      if (bus.stats_clr) m_cnt = 0;
      else begin
        m_cnt = m_cnt + $countones(e.d);
        if (m_cnt > 65535) m_cnt = 65535;
      end
`endif
    end
    e.es  = m_sticky;
    e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic chk(string nm, logic [NP*FW-1:0] act, logic [NP*FW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: one output set per cycle, compared just after the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("flit_out",     bus.flit_out,     e.flit);
        chk("valid_out",    bus.valid_out,    e.v);
        chk("deflect_out",  bus.deflect_out,  e.d);
        chk("err_conflict", bus.err_conflict, e.ec);
        chk("err_sticky",   bus.err_sticky,   e.es);
        chk("defl_count",   bus.defl_count,   e.cnt);
      end
    end
  end

  task automatic step();
    push_expected();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.flit_in      = '0;
    bus.valid_in     = '0;
    bus.prod_vector  = '0;
    bus.alloc_vector = '0;
    bus.stats_clr    = 1'b0;
  endtask

  task automatic set_perm(logic [FW-1:0] base);
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) begin
      r = NP'(1) << ((i + 1) % NP);
      bus.flit_in[i*FW +: FW]      = base + FW'(i);
      bus.alloc_vector[i*NP +: NP] = r;
      bus.prod_vector[i*PV +: PV]  = r;
    end
    bus.valid_in  = '1;
    bus.stats_clr = 1'b0;
  endtask

  task automatic set_random();
    int sel;
    for (int i = 0; i < NP; i++) begin
      sel = int'($urandom_range(0, 9));
      bus.flit_in[i*FW +: FW] = {$urandom, $urandom};
      bus.prod_vector[i*PV +: PV] = PV'($urandom);
      if (sel == 0)      bus.alloc_vector[i*NP +: NP] = '0;
      else if (sel == 1) bus.alloc_vector[i*NP +: NP] = NP'($urandom);
      else               bus.alloc_vector[i*NP +: NP] = NP'(1) << $urandom_range(0, NP-1);
    end
    bus.valid_in  = NP'($urandom);
    bus.stats_clr = ($urandom_range(0, 15) == 0);
  endtask

  initial begin : driver
    set_idle();
    reset = 1'b1;
    @(negedge clk);

    // reset with every flit valid -> outputs held at 0
    set_perm(64'hA000);
    step(); step();
    // release: first flit appears one cycle later
    reset = 1'b0;
    set_perm(64'hA0);
    step();
    set_perm(64'h1234_0000_0000_00A0);
    step();

    // single deflection on port 2
    set_idle();
    bus.valid_in[0]        = 1'b1;
    bus.flit_in[0 +: FW]   = 64'hDEAD_BEEF_0000_0001;
    bus.alloc_vector[0 +: NP] = 6'h04;
    bus.prod_vector[0 +: PV]  = 6'h01;
    step();

    // conflict: flits 1 and 3 both granted port 1
    set_idle();
    bus.valid_in              = 6'b001010;
    bus.flit_in[1*FW +: FW]   = 64'h1111;
    bus.flit_in[3*FW +: FW]   = 64'h3333;
    bus.alloc_vector[1*NP +: NP] = 6'h02;
    bus.alloc_vector[3*NP +: NP] = 6'h02;
    bus.prod_vector[1*PV +: PV]  = 6'h02;
    bus.prod_vector[3*PV +: PV]  = 6'h02;
    step();
    set_perm(64'hB0);
    step(); step();

    // lost flit: valid with all-zero row
    set_idle();
    bus.valid_in[0] = 1'b1;
    bus.flit_in[0 +: FW] = 64'h5555;
    step();
    // invalid flit with all-ones row is ignored
    reset = 1'b1;
    set_idle();
    step();
    reset = 1'b0;
    bus.valid_in              = 6'b000001;
    bus.flit_in[0 +: FW]      = 64'h77;
    bus.alloc_vector[0 +: NP] = 6'h08;
    bus.prod_vector[0 +: PV]  = 6'h08;
    bus.flit_in[2*FW +: FW]   = 64'h99;
    bus.alloc_vector[2*NP +: NP] = 6'h3F;
    step();

    // randomized traffic, occasional reset and stats clear
    for (int n = 0; n < 400; n++) begin
      set_random();
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;

    // counter saturation: 10922 cycles x 6 deflections = 0xFFFC, then +2 -> 0xFFFE
    reset = 1'b1; set_idle(); step(); reset = 1'b0;
    for (int n = 0; n < 10922; n++) begin
      set_perm(64'(n));
      bus.prod_vector = '0;
      step();
    end
    set_perm(64'hC0);
    bus.prod_vector = '0;
    bus.valid_in    = 6'b000011;
    step();
    set_perm(64'hD0);
    bus.prod_vector = '0;
    step(); step(); step();
    // clear wins over same-cycle deflection
    bus.stats_clr = 1'b1;
    step();
    bus.stats_clr = 1'b0;
    step();
    set_idle();
    step();

    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
